fb_write_arbiter: RTL

//  Owns the framebuffer RAM write port (port A) in the sdio_clk domain. Shares it

---
 rtl/fb_write_arbiter_if.sv | 30 +++
 rtl/fb_write_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter_if.sv
// Stream write channel into the framebuffer arbiter: a valid/ready pixel
// write plus the out-of-range drop indication returned to the producer.
interface fb_write_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  s_valid;
    logic                  s_ready;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_oob;

    // Pixel producer side (e.g. the SDIO stream unpacker)
    modport master (
        output s_valid,
        output s_addr,
        output s_data,
        input  s_ready,
        input  s_oob
    );

    // Arbiter side
    modport slave (
        input  s_valid,
        input  s_addr,
        input  s_data,
        output s_ready,
        output s_oob
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port owner. Shares RAM port A between the pixel stream and
// a rectangle-fill engine with round-robin arbitration, clips fills to the
// visible screen and registers the RAM write strobe, address and data.
module fb_write_arbiter #(
    parameter int unsigned H_RES      = 800,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fb_write_arbiter_if.slave     s,
    input  logic                  fill_start,
    input  logic [9:0]            fill_x,
    input  logic [8:0]            fill_y,
    input  logic [9:0]            fill_w,
    input  logic [8:0]            fill_h,
    input  logic [DATA_WIDTH-1:0] fill_color,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic                  fb_we,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic [DATA_WIDTH-1:0] fb_din
);

    localparam logic [ADDR_WIDTH-1:0] NPIX   = ADDR_WIDTH'(H_RES * V_RES);
    localparam logic [ADDR_WIDTH-1:0] H_STEP = ADDR_WIDTH'(H_RES);
    localparam logic [10:0]           X_LIM  = 11'(H_RES);
    localparam logic [9:0]            Y_LIM  = 10'(V_RES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FILL,
        ST_DONE
    } state_t;

    // Control state (asynchronously reset)
    state_t                state_q, state_d;
    logic                  rr_q, rr_d;           // 1: fill wins next contention
    logic                  fb_we_q, fb_we_d;
    logic                  s_oob_q, s_oob_d;
    logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
    logic [DATA_WIDTH-1:0] fb_din_q, fb_din_d;

    // Fill command and walk state (only meaningful once a command is latched)
    logic [9:0]            x0_q, x0_d;
    logic [8:0]            y0_q, y0_d;
    logic [9:0]            w_q, w_d;
    logic [8:0]            h_q, h_d;
    logic [DATA_WIDTH-1:0] color_q, color_d;
    logic [10:0]           x_end_q, x_end_d;     // exclusive, clipped to H_RES
    logic [9:0]            y_end_q, y_end_d;     // exclusive, clipped to V_RES
    logic [9:0]            x_cur_q, x_cur_d;
    logic [8:0]            y_cur_q, y_cur_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;

    logic        fill_req;
    logic        s_gnt;
    logic        f_gnt;
    logic        s_xfer;
    logic        s_in_range;
    logic [10:0] x_sum;
    logic [9:0]  y_sum;
    logic        degenerate;
    logic        x_last;
    logic        y_last;

    assign x_sum      = {1'b0, x0_q} + {1'b0, w_q};
    assign y_sum      = {1'b0, y0_q} + {1'b0, h_q};
    assign degenerate = (w_q == 10'd0) || (h_q == 9'd0) ||
                        ({1'b0, x0_q} >= X_LIM) || ({1'b0, y0_q} >= Y_LIM);
    assign x_last     = ({1'b0, x_cur_q} == (x_end_q - 11'd1));
    assign y_last     = ({1'b0, y_cur_q} == (y_end_q - 10'd1));

    assign fill_req   = (state_q == ST_FILL);
    assign s_xfer     = s.s_valid & s_gnt;
    assign s_in_range = (s.s_addr < NPIX);

    assign s.s_ready  = s_gnt;
    assign s.s_oob    = s_oob_q;
    assign fill_busy  = (state_q != ST_IDLE);
    assign fill_done  = (state_q == ST_DONE);
    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_din     = fb_din_q;

    // Round-robin grant; the pointer only moves when both sides request
    always_comb begin
        s_gnt = 1'b0;
        f_gnt = 1'b0;
        rr_d  = rr_q;
        if (s.s_valid && fill_req) begin
            s_gnt = ~rr_q;
            f_gnt = rr_q;
            rr_d  = ~rr_q;
        end else begin
            s_gnt = ~fill_req;
            f_gnt = fill_req;
        end
    end

    // Fill engine next state: latch, clip, then walk the rectangle row by row
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        x_cur_d    = x_cur_q;
        y_cur_d    = y_cur_q;
        row_base_d = row_base_q;
        case (state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    x0_d    = fill_x;
                    y0_d    = fill_y;
                    w_d     = fill_w;
                    h_d     = fill_h;
                    color_d = fill_color;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                x_end_d    = (x_sum > X_LIM) ? X_LIM : x_sum;
                y_end_d    = (y_sum > Y_LIM) ? Y_LIM : y_sum;
                x_cur_d    = x0_q;
                y_cur_d    = y0_q;
                row_base_d = ADDR_WIDTH'(y0_q) * H_STEP;
                state_d    = degenerate ? ST_DONE : ST_FILL;
            end
            ST_FILL: begin
                if (f_gnt) begin
                    if (x_last) begin
                        if (y_last) begin
                            state_d = ST_DONE;
                        end else begin
                            x_cur_d    = x0_q;
                            y_cur_d    = y_cur_q + 9'd1;
                            row_base_d = row_base_q + H_STEP;
                        end
                    end else begin
                        x_cur_d = x_cur_q + 10'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM port next values: granted beat is written, out-of-range stream beat is dropped
    always_comb begin
        fb_we_d   = 1'b0;
        s_oob_d   = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_din_d  = fb_din_q;
        if (f_gnt) begin
            fb_we_d   = 1'b1;
            fb_addr_d = row_base_q + ADDR_WIDTH'(x_cur_q);
            fb_din_d  = color_q;
        end else if (s_xfer) begin
            if (s_in_range) begin
                fb_we_d   = 1'b1;
                fb_addr_d = s.s_addr;
                fb_din_d  = s.s_data;
            end else begin
                s_oob_d = 1'b1;
            end
        end
    end

    // Control and RAM port registers; reset aborts any fill in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_q      <= 1'b0;
            fb_we_q   <= 1'b0;
            s_oob_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_din_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            fb_we_q   <= fb_we_d;
            s_oob_q   <= s_oob_d;
            fb_addr_q <= fb_addr_d;
            fb_din_q  <= fb_din_d;
        end
    end

    // Fill command and walk registers, qualified by the FSM so no reset is needed
    always_ff @(posedge clk) begin
        x0_q       <= x0_d;
        y0_q       <= y0_d;
        w_q        <= w_d;
        h_q        <= h_d;
        color_q    <= color_d;
        x_end_q    <= x_end_d;
        y_end_q    <= y_end_d;
        x_cur_q    <= x_cur_d;
        y_cur_q    <= y_cur_d;
        row_base_q <= row_base_d;
    end

endmodule
